// File: rtl/sys_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_rst_seq_if
// Brief    : Control/status bundle between software/watchdog logic and the
//            staged reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface sys_rst_seq_if #(
    parameter int N_STAGES = 4,
    parameter int WDT_W    = 24
);
    logic                sw_rst_req;
    logic                wdt_ena;
    logic                wdt_kick;
    logic [WDT_W-1:0]    wdt_period;
    logic [N_STAGES-1:0] rst_out;
    logic                ready;
    logic [1:0]          rst_cause;
    logic [7:0]          rst_count;

    modport master (
        output sw_rst_req, wdt_ena, wdt_kick, wdt_period,
        input  rst_out, ready, rst_cause, rst_count
    );

    modport slave (
        input  sw_rst_req, wdt_ena, wdt_kick, wdt_period,
        output rst_out, ready, rst_cause, rst_count
    );
endinterface
`default_nettype wire

// File: rtl/sys_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : sys_rst_seq
// Brief    : Staged reset sequencer with watchdog; releases subsystem resets
//            in ascending order and re-sequences on SW request or WDT expiry.
// Revision : 1.0 - initial release
// ============================================================================
module sys_rst_seq #(
    parameter int N_STAGES  = 4,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_DLY = 8,
    parameter int WDT_W     = 24
) (
    input  wire logic    clk,
    input  wire logic    rst,
    sys_rst_seq_if.slave bus
);
    localparam int c_CNT_MAX = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_DLY_LAST  = c_CNT_W'(STAGE_DLY - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_STAGES - 1);

    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;

    localparam logic [1:0] c_CAUSE_POR = 2'd0;
    localparam logic [1:0] c_CAUSE_SW  = 2'd1;
    localparam logic [1:0] c_CAUSE_WDT = 2'd2;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [N_STAGES-1:0] r_rst_out;
    logic                r_ready;
    logic [1:0]          r_cause;
    logic [7:0]          r_count;
    logic [WDT_W-1:0]    r_wdt_cnt;

    logic                w_wdt_active;
    logic [WDT_W-1:0]    w_wdt_last;
    logic                w_expire;
    logic                w_trigger;

    // A kick in the would-be expiry cycle suppresses the expiry.
    assign w_wdt_active = (r_state == c_ST_RUN) && bus.wdt_ena && (bus.wdt_period != '0);
    assign w_wdt_last   = bus.wdt_period - WDT_W'(1);
    assign w_expire     = w_wdt_active && !bus.wdt_kick && (r_wdt_cnt == w_wdt_last);
    assign w_trigger    = bus.sw_rst_req || w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_cause   <= c_CAUSE_POR;
            r_count   <= 8'd0;
            r_wdt_cnt <= '0;
        end else if (w_trigger) begin
            r_state   <= c_ST_ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_cause   <= bus.sw_rst_req ? c_CAUSE_SW : c_CAUSE_WDT;
            r_count   <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
            r_wdt_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_ASSERT: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state <= c_ST_RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RELEASE: begin
                    if (r_cnt == c_DLY_LAST) begin
                        r_rst_out[r_idx] <= 1'b0;
                        r_cnt            <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_RUN;
                            r_ready <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    r_state <= c_ST_RUN;
                end
                default: begin
                    r_state   <= c_ST_ASSERT;
                    r_cnt     <= '0;
                    r_idx     <= '0;
                    r_rst_out <= '1;
                    r_ready   <= 1'b0;
                end
            endcase

            if (!w_wdt_active || bus.wdt_kick) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            end
        end
    end

    assign bus.rst_out   = r_rst_out;
    assign bus.ready     = r_ready;
    assign bus.rst_cause = r_cause;
    assign bus.rst_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sys_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_rst_seq
// Brief    : Scoreboard bench for sys_rst_seq against an elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_rst_seq;
    localparam int N = 4;
    localparam int H = 16;
    localparam int D = 8;
    localparam int W = 24;

    typedef struct {
        logic [N-1:0] rst_out;
        logic         ready;
        logic [1:0]   cause;
        logic [7:0]   count;
    } exp_t;

    logic clk_1x;
    logic rst;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    // Reference model: age = rising edges since the sequence last (re)started.
    int m_age;
    int m_wdt;
    int m_cause;
    int m_count;

    sys_rst_seq_if #(.N_STAGES(N), .WDT_W(W)) bus ();

    sys_rst_seq #(
        .N_STAGES (N),
        .HOLD_CYC (H),
        .STAGE_DLY(D),
        .WDT_W    (W)
    ) u_dut (
        .clk(clk_1x),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk_1x = 1'b0;
        forever #5 clk_1x = ~clk_1x;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model the next edge from the currently applied inputs, then take that edge.
    task automatic cycle();
        bit   in_run;
        bit   active;
        bit   expire;
        exp_t e;
        if (rst) begin
            m_age = 0; m_cause = 0; m_count = 0; m_wdt = 0;
        end else begin
            in_run = (m_age >= H + N*D);
            active = in_run && bus.wdt_ena && (bus.wdt_period != 0);
            expire = active && !bus.wdt_kick && (m_wdt == int'(bus.wdt_period) - 1);
            if (bus.sw_rst_req || expire) begin
                m_age   = 0;
                m_cause = bus.sw_rst_req ? 1 : 2;
                if (m_count < 255) m_count++;
                m_wdt   = 0;
            end else begin
                m_age++;
                m_wdt = (!active || bus.wdt_kick) ? 0 : ((m_wdt + 1) % (1 << W));
            end
        end
        for (int k = 0; k < N; k++) e.rst_out[k] = (m_age < H + (k+1)*D);
        e.ready = (m_age >= H + N*D);
        e.cause = m_cause[1:0];
        e.count = m_count[7:0];
        sb.push_back(e);
        @(posedge clk_1x);
        #1;
    endtask

    task automatic step(input bit sw, input bit kick);
        bus.sw_rst_req = sw;
        bus.wdt_kick   = kick;
        cycle();
        bus.sw_rst_req = 1'b0;
        bus.wdt_kick   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_1x);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rst_out",   32'(bus.rst_out),   32'(e.rst_out));
                chk("ready",     32'(bus.ready),     32'(e.ready));
                chk("rst_cause", 32'(bus.rst_cause), 32'(e.cause));
                chk("rst_count", 32'(bus.rst_count), 32'(e.count));
            end
        end
    end

    initial begin : timeout
        #3000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int periods[5];
        periods = '{0, 5, 30, 60, 200};
        n_checks = 0; n_fail = 0;
        m_age = 0; m_wdt = 0; m_cause = 0; m_count = 0;
        rst = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.wdt_kick   = 1'b0;
        bus.wdt_ena    = 1'b0;
        bus.wdt_period = '0;

        // Power-on reset and default release timing
        idle(3);
        rst = 1'b0;
        idle(60);

        // Unkicked watchdog expiry and re-release
        bus.wdt_ena = 1'b1;
        bus.wdt_period = 24'd100;
        idle(200);

        // Kicked watchdog, first kick lands exactly in the expiry cycle
        bus.wdt_ena = 1'b0;
        idle(60);
        bus.wdt_ena = 1'b1;
        for (int c = 0; c < 10000; c++)
            step(1'b0, (c >= 99) && (((c - 99) % 99) == 0));
        bus.wdt_period = '0;
        idle(300);

        // SW restart while stage index 2 is pending
        bus.wdt_ena = 1'b0;
        step(1'b1, 1'b0);
        idle(H + 2*D + 3);
        step(1'b1, 1'b0);
        idle(60);

        // SW request coincident with watchdog expiry
        bus.wdt_ena = 1'b1;
        bus.wdt_period = 24'd20;
        idle(19);
        step(1'b1, 1'b0);
        bus.wdt_ena = 1'b0;
        idle(60);

        // Count saturation, then rst mid-release
        for (int p = 0; p < 260; p++) begin
            step(1'b1, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(30);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(60);

        // Randomized mix
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0)  bus.wdt_ena = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) bus.wdt_period = 24'(periods[$urandom_range(0, 4)]);
            rst = ($urandom_range(0, 1499) == 0);
            step($urandom_range(0, 249) == 0, $urandom_range(0, 39) == 0);
        end
        rst = 1'b0;
        idle(5);

        @(negedge clk_1x);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
